ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Camera-side writer for the 128x128 RGB444 frame buffer. Samples the OV7670 parallel pixel bus (pclk/href/vsync/data) in the system clock domain and pairs the two RGB444 bytes of each pixel into one 12-bit word. Crops the incoming frame to the buffer window and drives the buffer's write port (wea/addra/dina) in row-major order, so that address = row*c_img_cols + col. Signals frame completion to downstream logic.

## Interface
- c_img_cols, 128: buffer columns; pixels beyond this in a line are dropped
- c_img_rows, 128: buffer rows; lines beyond this in a frame are dropped
- c_nb_img_pxls, 14: address width, ≥ clog2(c_img_cols*c_img_rows)
- c_nb_buf, 12: buffer word width, {R[3:0],G[3:0],B[3:0]}
- clk  in  1  system clock; must be ≥ 3x cam_pclk frequency
- rst  in  1  reset, asynchronous, active-high
- cap_en  in  1  capture enable, sampled only at frame start
- cam_pclk  in  1  camera pixel clock (asynchronous, treated as data)
- cam_vsync  in  1  camera vsync, high between frames
- cam_href  in  1  camera line valid
- cam_data  in  8  camera byte
- wea  out  1  buffer write strobe, one clk per pixel
- addra  out  c_nb_img_pxls  buffer write address
- dina  out  c_nb_buf  pixel word
- frame_done  out  1  one-clk pulse after the last pixel of a complete frame
- busy  out  1  high while in CAPTURE

## Operation
- All cam_* inputs pass through a 2-flop synchronizer plus one history flop; pclk rise = sync2 & ~hist. href/vsync/data are used from sync2 at that cycle.
- FSM states: WAIT_VS (wait vsync high), WAIT_START (wait vsync falling), CAPTURE.
- WAIT_VS -> WAIT_START on vsync=1. WAIT_START -> CAPTURE on vsync 1->0 with cap_en=1; with cap_en=0 returns to WAIT_VS.
- CAPTURE: on each pclk rise with href=1, toggle byte phase. Phase 0 latches data[3:0] as R. Phase 1 forms {R, data[7:4], data[3:0]}.
- Phase-1 pixel written only if col < c_img_cols and row < c_img_rows. addra = line_base + col; col increments per pixel (saturating at c_img_cols).
- href falling edge: phase := 0, col := 0. If at least one byte was seen in the line, row += 1 and line_base += c_img_cols. No multiplier is used.
- Short line (< c_img_cols pixels): the remaining addresses in that row are left unwritten; the next line still starts at its own row base.
- Odd byte count in a line: the dangling byte is discarded at href fall.
- vsync rising in CAPTURE: if row ≥ c_img_rows, pulse frame_done. Otherwise abort without pulse. Both cases go to WAIT_START with row, line_base, col and phase cleared.
- Reset mid-frame: all outputs 0, state WAIT_VS. The remainder of the current frame is ignored until the next vsync falling edge.

## Timing
- Reset values: wea=0, addra=0, dina=0, frame_done=0, busy=0. Internal counters are 0 and the FSM is in WAIT_VS.
- wea/addra/dina are registered. wea is high for exactly one clk, two clk edges after the edge at which cam_pclk is first sampled high (phase-1 byte). addra/dina are valid in the same cycle.
- frame_done is high for one clk, 3 clk after vsync first samples high. busy falls in the same cycle.
- Minimum spacing between wea pulses: 2 pclk periods.

## Configuration
- CAP_DECIM2_EN defined: 2:1 decimation. Every other pixel (odd col index dropped) and every other line (odd line dropped) are discarded before windowing, so 256x256 of source covers 128x128 of buffer.
- Not defined: every pixel and line is captured 1:1, subject to the crop window.

## Structure
- Package cam_cap_pkg: FSM state enum (WAIT_VS, WAIT_START, CAPTURE) and RGB444 field width constants (C_NB_R/G/B = 4).
- Sub-module cam_sync_edge: 2-flop synchronizer plus history flop for pclk/href/vsync/data. Outputs pclk_rise, href_fall, vsync_rise, vsync_fall and the aligned byte.

## Test plan
- Full frame, 128 lines x 128 pixels, byte pairs (0x0A, 0xBC) -> 16384 wea pulses, dina=0xABC, addra 0..16383 in order, single frame_done.
- 160-pixel lines, 140 lines -> only col<128 and row<128 written. Last addra=16383; frame_done pulses.
- Line 5 with only 100 pixels -> row 5 has addra 640..739 written, and line 6 starts at addra 768.
- vsync rises after 50 lines -> no frame_done. The next frame starts again at addra 0.
- rst asserted mid-line -> outputs 0 immediately with no further wea until the next vsync fall. cap_en=0 at frame start -> no wea for that frame.
- With CAP_DECIM2_EN: 256x256 source where pixel = col index -> buffer col n holds source col 2n. frame_done is asserted.

Source files
------------

// File: rtl/cam_cap_pkg.sv
// Shared types and field widths for the OV7670 frame-buffer writer.
package cam_cap_pkg;

   localparam int unsigned C_NB_R   = 4;
   localparam int unsigned C_NB_G   = 4;
   localparam int unsigned C_NB_B   = 4;
   localparam int unsigned C_NB_CAM = 8;

   typedef enum logic [1:0] {
      WAIT_VS,
      WAIT_START,
      CAPTURE
   } cap_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Brings the camera bus into the clk domain: 2-flop synchronizer on every line plus a
// history flop on pclk/href/vsync for edge detection.
module cam_sync_edge
   import cam_cap_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_pclk,
   input  logic                i_href,
   input  logic                i_vsync,
   input  logic [C_NB_CAM-1:0] i_data,
   output logic                o_pclk_rise,
   output logic                o_href,
   output logic                o_href_fall,
   output logic                o_vsync,
   output logic                o_vsync_rise,
   output logic                o_vsync_fall,
   output logic [C_NB_CAM-1:0] o_data
);

   localparam int unsigned C_W = C_NB_CAM + 3;

   logic [C_W-1:0] r_s1, r_s2;
   logic [2:0]     r_hist;
   logic [C_W-1:0] w_in;
   logic [2:0]     w_ctl;

   assign w_in  = {i_pclk, i_href, i_vsync, i_data};
   assign w_ctl = r_s2[C_W-1:C_W-3];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_hist <= '0;
      end else begin
         r_s1   <= w_in;
         r_s2   <= r_s1;
         r_hist <= w_ctl;
      end
   end

   // w_ctl / r_hist bit order: {pclk, href, vsync}
   assign o_pclk_rise  = w_ctl[2] & ~r_hist[2];
   assign o_href       = w_ctl[1];
   assign o_href_fall  = ~w_ctl[1] & r_hist[1];
   assign o_vsync      = w_ctl[0];
   assign o_vsync_rise = w_ctl[0] & ~r_hist[0];
   assign o_vsync_fall = ~w_ctl[0] & r_hist[0];
   assign o_data       = r_s2[C_NB_CAM-1:0];

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture into a cropped row-major RGB444 frame buffer write port.
// Optional 2:1 source decimation is compiled in with CAP_DECIM2_EN.
module ov7670_capture
   import cam_cap_pkg::*;
#(
   parameter int unsigned c_img_cols    = 128,
   parameter int unsigned c_img_rows    = 128,
   parameter int unsigned c_nb_img_pxls = 14,
   parameter int unsigned c_nb_buf      = 12
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cap_en,
   input  logic                     i_cam_pclk,
   input  logic                     i_cam_vsync,
   input  logic                     i_cam_href,
   input  logic [C_NB_CAM-1:0]      i_cam_data,
   output logic                     o_wea,
   output logic [c_nb_img_pxls-1:0] o_addra,
   output logic [c_nb_buf-1:0]      o_dina,
   output logic                     o_frame_done,
   output logic                     o_busy
);

   localparam int unsigned C_NB_COL = $clog2(c_img_cols + 1);
   localparam int unsigned C_NB_ROW = $clog2(c_img_rows + 1);
   localparam logic [C_NB_COL-1:0]      C_COL_MAX   = C_NB_COL'(c_img_cols);
   localparam logic [C_NB_ROW-1:0]      C_ROW_MAX   = C_NB_ROW'(c_img_rows);
   localparam logic [c_nb_img_pxls-1:0] C_LINE_STEP = c_nb_img_pxls'(c_img_cols);

   cap_state_t               r_state, w_state_next;
   logic                     r_phase, w_phase_next;
   logic                     r_seen, w_seen_next;
   logic [C_NB_R-1:0]        r_red, w_red_next;
   logic [C_NB_COL-1:0]      r_col, w_col_next;
   logic [C_NB_ROW-1:0]      r_row, w_row_next;
   logic [c_nb_img_pxls-1:0] r_line_base, w_line_base_next;
   logic                     r_wea, w_wea_next;
   logic [c_nb_img_pxls-1:0] r_addra, w_addra_next;
   logic [c_nb_buf-1:0]      r_dina, w_dina_next;
   logic                     r_frame_done, w_frame_done_next;

   logic                w_pclk_rise, w_href, w_href_fall;
   logic                w_vsync, w_vsync_rise, w_vsync_fall;
   logic [C_NB_CAM-1:0] w_data;
   logic                w_px_keep, w_ln_keep;

   cam_sync_edge u_sync (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pclk       (i_cam_pclk),
      .i_href       (i_cam_href),
      .i_vsync      (i_cam_vsync),
      .i_data       (i_cam_data),
      .o_pclk_rise  (w_pclk_rise),
      .o_href       (w_href),
      .o_href_fall  (w_href_fall),
      .o_vsync      (w_vsync),
      .o_vsync_rise (w_vsync_rise),
      .o_vsync_fall (w_vsync_fall),
      .o_data       (w_data)
   );

`ifdef CAP_DECIM2_EN
   // Source pixel/line parity; odd ones are dropped before the crop window applies.
   logic r_px_odd, r_ln_odd;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_px_odd <= 1'b0;
         r_ln_odd <= 1'b0;
      end else if (r_state != CAPTURE) begin
         r_px_odd <= 1'b0;
         r_ln_odd <= 1'b0;
      end else if (!w_vsync_rise) begin
         if (w_href_fall) begin
            r_px_odd <= 1'b0;
            if (r_seen) r_ln_odd <= ~r_ln_odd;
         end else if (w_pclk_rise && w_href && r_phase) begin
            r_px_odd <= ~r_px_odd;
         end
      end
   end

   assign w_px_keep = ~r_px_odd;
   assign w_ln_keep = ~r_ln_odd;
`else
   assign w_px_keep = 1'b1;
   assign w_ln_keep = 1'b1;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= WAIT_VS;
         r_phase      <= 1'b0;
         r_seen       <= 1'b0;
         r_red        <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_line_base  <= '0;
         r_wea        <= 1'b0;
         r_addra      <= '0;
         r_dina       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_phase      <= w_phase_next;
         r_seen       <= w_seen_next;
         r_red        <= w_red_next;
         r_col        <= w_col_next;
         r_row        <= w_row_next;
         r_line_base  <= w_line_base_next;
         r_wea        <= w_wea_next;
         r_addra      <= w_addra_next;
         r_dina       <= w_dina_next;
         r_frame_done <= w_frame_done_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_phase_next      = r_phase;
      w_seen_next       = r_seen;
      w_red_next        = r_red;
      w_col_next        = r_col;
      w_row_next        = r_row;
      w_line_base_next  = r_line_base;
      w_wea_next        = 1'b0;
      w_addra_next      = r_addra;
      w_dina_next       = r_dina;
      w_frame_done_next = 1'b0;

      unique case (r_state)
         WAIT_VS: begin
            if (w_vsync) w_state_next = WAIT_START;
         end
         WAIT_START: begin
            if (w_vsync_fall) w_state_next = i_cap_en ? CAPTURE : WAIT_VS;
         end
         CAPTURE: begin
            if (w_vsync_rise) begin
               w_state_next      = WAIT_START;
               w_frame_done_next = (r_row >= C_ROW_MAX);
            end else if (w_href_fall) begin
               w_phase_next = 1'b0;
               w_col_next   = '0;
               w_seen_next  = 1'b0;
               // Row base advances by addition so no multiplier is needed.
               if (r_seen && w_ln_keep && (r_row < C_ROW_MAX)) begin
                  w_row_next       = r_row + 1'b1;
                  w_line_base_next = r_line_base + C_LINE_STEP;
               end
            end else if (w_pclk_rise && w_href) begin
               w_seen_next = 1'b1;
               if (!r_phase) begin
                  w_phase_next = 1'b1;
                  w_red_next   = w_data[C_NB_R-1:0];
               end else begin
                  w_phase_next = 1'b0;
                  if (w_px_keep) begin
                     if (w_ln_keep && (r_col < C_COL_MAX) && (r_row < C_ROW_MAX)) begin
                        w_wea_next   = 1'b1;
                        w_addra_next = r_line_base + c_nb_img_pxls'(r_col);
                        w_dina_next  = c_nb_buf'({r_red, w_data[C_NB_G+C_NB_B-1:C_NB_B],
                                                  w_data[C_NB_B-1:0]});
                     end
                     if (r_col < C_COL_MAX) w_col_next = r_col + 1'b1;
                  end
               end
            end
         end
         default: w_state_next = WAIT_VS;
      endcase

      if (r_state != CAPTURE) begin
         w_phase_next     = 1'b0;
         w_seen_next      = 1'b0;
         w_col_next       = '0;
         w_row_next       = '0;
         w_line_base_next = '0;
      end
   end

   assign o_wea        = r_wea;
   assign o_addra      = r_addra;
   assign o_dina       = r_dina;
   assign o_frame_done = r_frame_done;
   assign o_busy       = (r_state == CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 16x8 window; frames come from a table,
// corner cases (latency, reset mid-line) are hand-written sequences.
`timescale 1ns/1ps
module tb_ov7670_capture;

   localparam int COLS    = 16;
   localparam int ROWS    = 8;
   localparam int NB_ADDR = 7;
   localparam int NB_BUF  = 12;
`ifdef CAP_DECIM2_EN
   localparam int DEC = 2;
   localparam int NV  = 3;
`else
   localparam int DEC = 1;
   localparam int NV  = 7;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cap_en = 1'b0;
   logic cam_pclk = 1'b0;
   logic cam_vsync = 1'b0;
   logic cam_href = 1'b0;
   logic [7:0] cam_data = 8'h00;
   logic wea;
   logic [NB_ADDR-1:0] addra;
   logic [NB_BUF-1:0] dina;
   logic frame_done;
   logic busy;

   always #5 clk = ~clk;

   ov7670_capture #(
      .c_img_cols    (COLS),
      .c_img_rows    (ROWS),
      .c_nb_img_pxls (NB_ADDR),
      .c_nb_buf      (NB_BUF)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cap_en     (cap_en),
      .i_cam_pclk   (cam_pclk),
      .i_cam_vsync  (cam_vsync),
      .i_cam_href   (cam_href),
      .i_cam_data   (cam_data),
      .o_wea        (wea),
      .o_addra      (addra),
      .o_dina       (dina),
      .o_frame_done (frame_done),
      .o_busy       (busy)
   );

   typedef struct {
      int n_lines;
      int n_pix;
      int short_line;
      int short_len;
      int odd_line;
      int cap;
      int pat;
      int exp_wr;
      int exp_done;
      int exp_last;
   } vec_t;

   vec_t tbl [NV];

   int n_checks = 0;
   int n_fail   = 0;

   int exp_mem [COLS*ROWS];
   int got_mem [COLS*ROWS];
   int got_addr [256];
   int wr_n, done_n, last_addr, order_bad, busy_bad, width_bad;
   bit prev_done;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_sb();
      for (int i = 0; i < COLS*ROWS; i++) begin
         exp_mem[i] = -1;
         got_mem[i] = -1;
      end
      wr_n = 0; done_n = 0; last_addr = -1;
      order_bad = 0; busy_bad = 0; width_bad = 0;
   endtask

   function automatic logic [11:0] pix_val(input int pat, input int l, input int c);
      logic [11:0] p;
      case (pat)
         0:       p = 12'hABC;
         1:       p = 12'(c);
         default: p = {4'(l) ^ 4'h3, 8'(c)};
      endcase
      return p;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      cam_data = b;
      cam_pclk = 1'b0;
      clk_n(2);
      cam_pclk = 1'b1;
      clk_n(2);
   endtask

   task automatic send_line(input int l, input int npix, input bit odd, input int pat,
                            input bit model);
      logic [11:0] p;
      cam_href = 1'b1;
      for (int c = 0; c < npix; c++) begin
         p = pix_val(pat, l, c);
         send_byte((pat == 0) ? 8'h0A : {4'hF, p[11:8]});
         send_byte(p[7:0]);
         if (model && (l % DEC == 0) && (c % DEC == 0) && (l / DEC < ROWS) && (c / DEC < COLS))
            exp_mem[(l / DEC) * COLS + c / DEC] = int'(p);
      end
      if (odd) send_byte(8'hE7);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clk_n(4);
   endtask

   task automatic frame_start();
      cam_vsync = 1'b1;
      clk_n(6);
      cam_vsync = 1'b0;
      clk_n(6);
   endtask

   task automatic frame_end();
      cam_vsync = 1'b1;
      clk_n(8);
   endtask

   // Write-port / frame_done monitor
   initial begin
      clear_sb();
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (wea) begin
            if (wr_n > 0 && int'(addra) <= last_addr) order_bad++;
            if (wr_n < 256) got_addr[wr_n] = int'(addra);
            if (int'(addra) < COLS*ROWS) got_mem[addra] = int'(dina);
            last_addr = int'(addra);
            wr_n++;
         end
         if (frame_done) begin
            done_n++;
            if (busy) busy_bad++;
            if (prev_done) width_bad++;
         end
         prev_done = frame_done;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mism, first_bad, idx;
`ifdef CAP_DECIM2_EN
      tbl[0] = '{16, 32, -1, 0, -1, 1, 1, 128, 1, 127};
      tbl[1] = '{20, 40, -1, 0, -1, 1, 2, 128, 1, 127};
      tbl[2] = '{6,  32, -1, 0, -1, 1, 1, 48,  0, 47};
`else
      tbl[0] = '{8,  16, -1, 0,  -1, 1, 0, 128, 1, 127};
      tbl[1] = '{10, 20, -1, 0,  -1, 1, 2, 128, 1, 127};
      tbl[2] = '{8,  16, 5,  10, -1, 1, 1, 122, 1, 127};
      tbl[3] = '{3,  16, -1, 0,  -1, 1, 1, 48,  0, 47};
      tbl[4] = '{8,  16, -1, 0,  -1, 1, 2, 128, 1, 127};
      tbl[5] = '{8,  16, -1, 0,  -1, 0, 0, 0,   0, 0};
      tbl[6] = '{8,  16, -1, 0,  2,  1, 1, 128, 1, 127};
`endif

      // Reset state
      clk_n(3);
      check("rst_wea", int'(wea), 0);
      check("rst_addra", int'(addra), 0);
      check("rst_dina", int'(dina), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      clk_n(2);

      // First-pixel latency: wea two clk edges after pclk is first sampled high
      clear_sb();
      cap_en = 1'b1;
      frame_start();
      check("busy_in_capture", int'(busy), 1);
      cam_href = 1'b1;
      send_byte(8'h03);
      cam_data = 8'h45;
      cam_pclk = 1'b0;
      clk_n(2);
      cam_pclk = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      check("lat_wea_e1", int'(wea), 0);
      @(posedge clk); #1;
      check("lat_wea_e2", int'(wea), 1);
      check("lat_dina", int'(dina), 'h345);
      check("lat_addra", int'(addra), 0);
      @(posedge clk); #1;
      check("lat_wea_e3", int'(wea), 0);
      @(negedge clk);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clk_n(4);
      frame_end();
      check("lat_writes", wr_n, 1);
      check("lat_abort_done", done_n, 0);

      // Reset mid-line, then the rest of that frame must be ignored
      clear_sb();
      frame_start();
      send_line(0, COLS, 1'b0, 1, 1'b0);
      send_line(1, COLS, 1'b0, 1, 1'b0);
      cam_href = 1'b1;
      for (int c = 0; c < 4; c++) begin
         send_byte(8'h0A);
         send_byte(8'hBC);
      end
      rst = 1'b1;
      #1;
      check("midrst_wea", int'(wea), 0);
      check("midrst_addra", int'(addra), 0);
      check("midrst_dina", int'(dina), 0);
      check("midrst_busy", int'(busy), 0);
      clk_n(2);
      rst = 1'b0;
      clear_sb();
      for (int c = 0; c < 4; c++) begin
         send_byte(8'h0A);
         send_byte(8'hBC);
      end
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clk_n(4);
      for (int l = 3; l < 6; l++) send_line(l, COLS, 1'b0, 1, 1'b0);
      frame_end();
      check("midrst_writes", wr_n, 0);
      check("midrst_done", done_n, 0);

      // Table-driven frames
      for (int v = 0; v < NV; v++) begin
         clear_sb();
         cap_en = (tbl[v].cap != 0);
         frame_start();
         for (int l = 0; l < tbl[v].n_lines; l++)
            send_line(l, (l == tbl[v].short_line) ? tbl[v].short_len : tbl[v].n_pix,
                      l == tbl[v].odd_line, tbl[v].pat, cap_en);
         frame_end();
         check($sformatf("v%0d_writes", v), wr_n, tbl[v].exp_wr);
         check($sformatf("v%0d_frame_done", v), done_n, tbl[v].exp_done);
         check($sformatf("v%0d_done_shape", v), busy_bad + width_bad, 0);
         check($sformatf("v%0d_addr_order", v), order_bad, 0);
         if (tbl[v].exp_wr > 0) begin
            check($sformatf("v%0d_first_addr", v), got_addr[0], 0);
            check($sformatf("v%0d_last_addr", v), last_addr, tbl[v].exp_last);
         end
         if (tbl[v].short_line >= 0) begin
            idx = tbl[v].short_line * COLS + tbl[v].short_len;
            check($sformatf("v%0d_short_tail", v), got_addr[idx-1], idx - 1);
            check($sformatf("v%0d_next_row_base", v), got_addr[idx],
                  (tbl[v].short_line + 1) * COLS);
         end
         mism = 0;
         first_bad = -1;
         for (int i = 0; i < COLS*ROWS; i++) begin
            if (exp_mem[i] != got_mem[i]) begin
               mism++;
               if (first_bad < 0) first_bad = i;
            end
         end
         if (mism != 0)
            $display("  v%0d first bad cell %0d: got %0d expected %0d", v, first_bad,
                     got_mem[first_bad], exp_mem[first_bad]);
         check($sformatf("v%0d_mem_cells_wrong", v), mism, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
